mem_accesser: RTL

- Memory-access stage directly downstream of the execute stage.
- Consumes the execute result (ALU value or effective address), the rs2 store data and the load/store controls.
- Performs byte/half/word loads and stores over a request/grant/response data-memory port; passes non-memory results straight through.
- Delivers a registered writeback packet to the writeback stage and back-pressures execute while a memory access is outstanding.

---
 rtl/mem_accesser.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_accesser.sv
// Memory-access stage: byte/half/word loads and stores over a req/gnt/rvalid port, ALU pass-through.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults instead of aligning them.
module mem_accesser #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        IS_LOAD,
  input  logic        IS_STORE,
  input  logic [2:0]  FUNCT3,
  input  logic [4:0]  RD,
  input  logic [31:0] EXEC_RESULT,
  input  logic [31:0] RS2_VAL,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_WSTRB,
  input  logic        MEM_GNT,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic        OUT_VALID,
  output logic        OUT_WE,
  output logic [4:0]  OUT_RD,
  output logic [31:0] OUT_DATA,
  output logic        ERR
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [1:0]  r_off;

  logic        r_mem_req, r_mem_we, r_out_valid, r_out_we, r_err;
  logic [31:0] r_mem_addr, r_mem_wdata, r_out_data;
  logic [3:0]  r_mem_wstrb;
  logic [4:0]  r_out_rd;

  logic        w_mem_req_nxt, w_mem_we_nxt, w_out_valid_nxt, w_out_we_nxt, w_err_nxt;
  logic [31:0] w_mem_addr_nxt, w_mem_wdata_nxt, w_out_data_nxt;
  logic [3:0]  w_mem_wstrb_nxt;
  logic [4:0]  w_out_rd_nxt;

  logic        w_accept, w_is_mem, w_is_st, w_illegal, w_misalign, w_fault, w_go_mem, w_tmo;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  assign IN_READY = (r_state == S_IDLE);
  assign w_accept = IN_READY && IN_VALID;
  assign w_is_mem = IS_LOAD | IS_STORE;
  assign w_is_st  = IS_STORE & ~IS_LOAD;
  assign w_illegal = w_is_st ? (FUNCT3 >= 3'd3)
                             : ((FUNCT3 == 3'b011) || (FUNCT3[2:1] == 2'b11));
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = ((FUNCT3[1:0] == 2'b01) && EXEC_RESULT[0]) ||
                      ((FUNCT3[1:0] == 2'b10) && (EXEC_RESULT[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif
  assign w_fault  = w_is_mem & (w_illegal | w_misalign);
  assign w_go_mem = w_is_mem & ~w_fault;
  assign w_tmo    = (MEM_TIMEOUT != 0) && (r_cnt == MEM_TIMEOUT - 1);

  always_comb begin
    w_byte = MEM_RDATA[7:0];
    unique case (r_off)
      2'd0: w_byte = MEM_RDATA[7:0];
      2'd1: w_byte = MEM_RDATA[15:8];
      2'd2: w_byte = MEM_RDATA[23:16];
      2'd3: w_byte = MEM_RDATA[31:24];
      default: w_byte = MEM_RDATA[7:0];
    endcase
    w_half = r_off[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    unique case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = MEM_RDATA;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_off    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == S_IDLE) ? '0 : r_cnt + 32'd1;
      if (w_accept && w_go_mem) begin
        r_funct3 <= FUNCT3;
        r_rd     <= RD;
        r_off    <= EXEC_RESULT[1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept && w_go_mem) w_state_nxt = S_REQ;
      S_REQ:    if (MEM_GNT) w_state_nxt = r_mem_we ? S_IDLE : S_WAIT_R;
                else if (w_tmo) w_state_nxt = S_IDLE;
      S_WAIT_R: if (MEM_RVALID || w_tmo) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; request fields hold unless a new access is issued.
  always_comb begin
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wstrb_nxt = r_mem_wstrb;
    w_out_valid_nxt = 1'b0;
    w_out_we_nxt    = 1'b0;
    w_err_nxt       = 1'b0;
    w_out_rd_nxt    = r_out_rd;
    w_out_data_nxt  = r_out_data;
    unique case (r_state)
      S_IDLE: if (w_accept) begin
        w_out_rd_nxt = RD;
        if (!w_is_mem) begin
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = EXEC_RESULT;
          w_out_we_nxt    = (RD != 5'd0);
        end else if (w_fault) begin
          w_out_valid_nxt = 1'b1;
          w_err_nxt       = 1'b1;
          w_out_data_nxt  = w_misalign ? EXEC_RESULT : '0;
        end else begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = w_is_st;
          w_mem_addr_nxt  = {EXEC_RESULT[31:2], 2'b00};
          w_mem_wdata_nxt = '0;
          w_mem_wstrb_nxt = '0;
          if (w_is_st) begin
            unique case (FUNCT3[1:0])
              2'b00: begin
                w_mem_wstrb_nxt = 4'b0001 << EXEC_RESULT[1:0];
                w_mem_wdata_nxt = {4{RS2_VAL[7:0]}};
              end
              2'b01: begin
                w_mem_wstrb_nxt = 4'b0011 << {EXEC_RESULT[1], 1'b0};
                w_mem_wdata_nxt = {2{RS2_VAL[15:0]}};
              end
              default: begin
                w_mem_wstrb_nxt = 4'b1111;
                w_mem_wdata_nxt = RS2_VAL;
              end
            endcase
          end
        end
      end
      S_REQ: if (MEM_GNT) begin
        w_mem_req_nxt = 1'b0;
        if (r_mem_we) begin
          w_out_valid_nxt = 1'b1;
          w_out_rd_nxt    = r_rd;
        end
      end else if (w_tmo) begin
        w_mem_req_nxt   = 1'b0;
        w_out_valid_nxt = 1'b1;
        w_err_nxt       = 1'b1;
        w_out_rd_nxt    = r_rd;
      end
      S_WAIT_R: if (MEM_RVALID) begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = w_load_val;
        w_out_rd_nxt    = r_rd;
        w_out_we_nxt    = (r_rd != 5'd0);
      end else if (w_tmo) begin
        w_out_valid_nxt = 1'b1;
        w_err_nxt       = 1'b1;
        w_out_rd_nxt    = r_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_out_valid <= 1'b0;
      r_out_we    <= 1'b0;
      r_err       <= 1'b0;
      r_out_rd    <= '0;
      r_out_data  <= '0;
    end else begin
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_wstrb <= w_mem_wstrb_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_we    <= w_out_we_nxt;
      r_err       <= w_err_nxt;
      r_out_rd    <= w_out_rd_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

  assign MEM_REQ   = r_mem_req;
  assign MEM_WE    = r_mem_we;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = r_mem_wdata;
  assign MEM_WSTRB = r_mem_wstrb;
  assign OUT_VALID = r_out_valid;
  assign OUT_WE    = r_out_we;
  assign OUT_RD    = r_out_rd;
  assign OUT_DATA  = r_out_data;
  assign ERR       = r_err;

endmodule
